// File: rtl/accum_group.sv
// Group accumulator: sums a valid/ready stream into one result per group,
// with optional sign extension, saturation and running-sum output.
module accum_group #(
  parameter int W_DATA_IN    = 8,
  parameter int W_DATA_OUT   = 32,
  parameter int W_EOT        = 2,
  parameter int EOT_LVL      = 0,
  parameter int SIGNED       = 0,
  parameter int SATURATE     = 0,
  parameter int EMIT_PARTIAL = 0,
  parameter int W_CNT        = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  din_valid,
  output logic                  din_ready,
  input  logic [W_DATA_IN-1:0]  din_data,
  input  logic [W_EOT-1:0]      din_eot,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic [W_DATA_OUT-1:0] dout_data,
  output logic [W_EOT-1:0]      dout_eot,
  output logic [W_CNT-1:0]      dout_count,
  output logic                  dout_ovf
);

  localparam int MSB = W_DATA_OUT - 1;

  logic [MSB:0]        acc;
  logic [MSB:0]        base;
  logic [MSB:0]        ext;
  logic [MSB:0]        res;
  logic [W_DATA_OUT:0] sum;
  logic [W_CNT-1:0]    cnt;
  logic [W_CNT-1:0]    cnt_n;
  logic                ovf;
  logic                ovf_n;
  logic                oflow;
  logic                first;
  logic                acc_en;
  logic                close;
  logic                emit;

  assign din_ready = rst && (!dout_valid || dout_ready);
  assign acc_en    = din_valid && din_ready;
  assign close     = din_eot[EOT_LVL];
  assign emit      = acc_en && (close || (EMIT_PARTIAL != 0));

  always_comb begin
    ext = '0;
    if ((SIGNED != 0) && din_data[W_DATA_IN-1])
      ext = '1;
    ext[W_DATA_IN-1:0] = din_data;
    base = first ? '0 : acc;
    sum  = {1'b0, base} + {1'b0, ext};
    if (SIGNED != 0)
      oflow = (base[MSB] == ext[MSB]) &&
              (sum[MSB] != base[MSB]);
    else
      oflow = sum[W_DATA_OUT];
    res = sum[MSB:0];
    // signed clamp direction follows the sign both operands shared
    if (oflow && (SATURATE != 0)) begin
      if (SIGNED == 0) begin
        res = '1;
      end else begin
        res      = base[MSB] ? '0 : '1;
        res[MSB] = base[MSB];
      end
    end
    if (first)
      cnt_n = W_CNT'(1);
    else if (&cnt)
      cnt_n = cnt;
    else
      cnt_n = cnt + W_CNT'(1);
    ovf_n = (!first && ovf) || oflow;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc        <= '0;
      cnt        <= '0;
      ovf        <= 1'b0;
      first      <= 1'b1;
      dout_valid <= 1'b0;
      dout_data  <= '0;
      dout_eot   <= '0;
      dout_count <= '0;
      dout_ovf   <= 1'b0;
    end else begin
      if (acc_en) begin
        acc   <= res;
        cnt   <= cnt_n;
        ovf   <= ovf_n;
        first <= close;
      end
      if (emit) begin
        dout_valid <= 1'b1;
        dout_data  <= res;
        dout_eot   <= din_eot;
        dout_count <= cnt_n;
        dout_ovf   <= ovf_n;
      end else if (dout_ready) begin
        dout_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_accum_group.sv
// Bench for accum_group: five parameter variants share one input stream
// and are checked against an integer-arithmetic reference model.
module tb_accum_group;

  localparam int N = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       din_valid;
  logic       dout_ready;
  logic [7:0] din_data;
  logic [1:0] din_eot;

  logic [N-1:0] rdy;
  logic [N-1:0] dv;
  logic [N-1:0] ov;
  logic [31:0]  od [N];
  logic [1:0]   oe [N];
  logic [15:0]  oc [N];
  logic [7:0]   d2;
  logic [7:0]   d3;
  logic [8:0]   d4;
  logic [2:0]   c1;

  assign od[2] = {24'b0, d2};
  assign od[3] = {24'b0, d3};
  assign od[4] = {23'b0, d4};
  assign oc[1] = {13'b0, c1};

  int     wout [N] = '{32, 32, 8, 8, 9};
  bit     sgn  [N] = '{0, 0, 1, 0, 0};
  bit     sat  [N] = '{0, 0, 1, 0, 1};
  bit     part [N] = '{0, 1, 1, 0, 0};
  int     lvl  [N] = '{0, 0, 0, 1, 0};
  longint cmax [N] = '{65535, 7, 65535, 65535, 65535};

  longint   m_acc [N];
  longint   m_cnt [N];
  bit       m_ovf [N];
  bit       m_first [N];
  bit       mv [N];
  longint   md [N];
  logic [1:0] meot [N];
  longint   mcnt [N];
  bit       movf [N];

  int total = 0;
  int bad = 0;

  accum_group u0 (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din_ready(rdy[0]),
    .din_data(din_data), .din_eot(din_eot), .dout_valid(dv[0]),
    .dout_ready(dout_ready), .dout_data(od[0]), .dout_eot(oe[0]),
    .dout_count(oc[0]), .dout_ovf(ov[0])
  );

  accum_group #(.EMIT_PARTIAL(1), .W_CNT(3)) u1 (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din_ready(rdy[1]),
    .din_data(din_data), .din_eot(din_eot), .dout_valid(dv[1]),
    .dout_ready(dout_ready), .dout_data(od[1]), .dout_eot(oe[1]),
    .dout_count(c1), .dout_ovf(ov[1])
  );

  accum_group #(.W_DATA_OUT(8), .SIGNED(1), .SATURATE(1),
    .EMIT_PARTIAL(1)) u2 (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din_ready(rdy[2]),
    .din_data(din_data), .din_eot(din_eot), .dout_valid(dv[2]),
    .dout_ready(dout_ready), .dout_data(d2), .dout_eot(oe[2]),
    .dout_count(oc[2]), .dout_ovf(ov[2])
  );

  accum_group #(.W_DATA_OUT(8), .EOT_LVL(1)) u3 (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din_ready(rdy[3]),
    .din_data(din_data), .din_eot(din_eot), .dout_valid(dv[3]),
    .dout_ready(dout_ready), .dout_data(d3), .dout_eot(oe[3]),
    .dout_count(oc[3]), .dout_ovf(ov[3])
  );

  accum_group #(.W_DATA_OUT(9), .SATURATE(1)) u4 (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din_ready(rdy[4]),
    .din_data(din_data), .din_eot(din_eot), .dout_valid(dv[4]),
    .dout_ready(dout_ready), .dout_data(d4), .dout_eot(oe[4]),
    .dout_count(oc[4]), .dout_ovf(ov[4])
  );

  // Advance one clock; the model works on true integer values and
  // folds them into the output range afterwards.
  task automatic tick();
    bit take, o, cl;
    longint v, t, lo, hi, r, span;
    for (int i = 0; i < N; i++) begin
      if (!rst) begin
        m_acc[i] = 0; m_cnt[i] = 0; m_ovf[i] = 0; m_first[i] = 1;
        mv[i] = 0; md[i] = 0; meot[i] = 0; mcnt[i] = 0; movf[i] = 0;
      end else begin
        take = din_valid && (!mv[i] || dout_ready);
        if (take) begin
          span = longint'(1) << wout[i];
          v  = sgn[i] ? longint'($signed(din_data)) : longint'(din_data);
          lo = sgn[i] ? -(span / 2) : 0;
          hi = sgn[i] ? span / 2 - 1 : span - 1;
          t  = (m_first[i] ? 0 : m_acc[i]) + v;
          o  = (t < lo) || (t > hi);
          if (!o) r = t;
          else if (sat[i]) r = (t > hi) ? hi : lo;
          else begin
            r = ((t % span) + span) % span;
            if (r > hi) r -= span;
          end
          if (m_first[i]) m_cnt[i] = 1;
          else if (m_cnt[i] + 1 > cmax[i]) m_cnt[i] = cmax[i];
          else m_cnt[i] = m_cnt[i] + 1;
          m_ovf[i] = (!m_first[i] && m_ovf[i]) || o;
          m_acc[i] = r;
          cl = din_eot[lvl[i]];
          m_first[i] = cl;
          if (cl || part[i]) begin
            mv[i] = 1; md[i] = r; meot[i] = din_eot;
            mcnt[i] = m_cnt[i]; movf[i] = m_ovf[i];
          end else if (mv[i] && dout_ready) begin
            mv[i] = 0;
          end
        end else if (mv[i] && dout_ready) begin
          mv[i] = 0;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b0; din_valid = 1'b0; dout_ready = 1'b1;
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; din_valid = 1'b1; din_data = 8'h11; din_eot = 2'b11;
    dout_ready = 1'b1;
    tick();
    tick();
    #1;
    for (int i = 0; i < N; i++) begin
      total++;
      if ({rdy[i], dv[i], ov[i], od[i], oe[i], oc[i]} !== 53'b0) begin
        bad++;
        $display("FAIL reset_outs[%0d]: got rdy=%b v=%b ovf=%b d=%0h e=%0h c=%0h want all 0",
                 i, rdy[i], dv[i], ov[i], od[i], oe[i], oc[i]);
      end
    end
    din_valid = 1'b0;
    rst = 1'b1;
  endtask

  task automatic test_group();
    int dat [3] = '{3, 5, 7};
    logic [1:0] eot [3] = '{2'b00, 2'b00, 2'b01};
    apply_reset();
    for (int k = 0; k < 3; k++) begin
      din_valid = 1'b1; din_data = 8'(dat[k]); din_eot = eot[k];
      tick();
      if (k < 2) begin
        total++;
        if (dv[0] !== 1'b0) begin
          bad++; $display("FAIL grp_no_out: got %b want 0", dv[0]);
        end
      end
    end
    total++;
    if (dv[0] !== 1'b1 || od[0] !== 32'd15 || oc[0] !== 16'd3 ||
        oe[0] !== 2'b01 || ov[0] !== 1'b0) begin
      bad++;
      $display("FAIL grp_result: got v=%b d=%0d c=%0d e=%b o=%b want 1 15 3 01 0",
               dv[0], od[0], oc[0], oe[0], ov[0]);
    end
    din_valid = 1'b0;
    tick();
    total++;
    if (dv[0] !== 1'b0) begin
      bad++; $display("FAIL grp_drain: got %b want 0", dv[0]);
    end
  endtask

  task automatic test_partial();
    int dat [4] = '{1, 2, 3, 4};
    int exd [4] = '{1, 3, 6, 4};
    int exc [4] = '{1, 2, 3, 1};
    logic [1:0] eot [4] = '{2'b00, 2'b00, 2'b01, 2'b01};
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      din_valid = 1'b1; din_data = 8'(dat[k]); din_eot = eot[k];
      tick();
      total++;
      if (dv[1] !== 1'b1 || od[1] !== 32'(exd[k]) || oc[1] !== 16'(exc[k])) begin
        bad++;
        $display("FAIL part_beat%0d: got v=%b d=%0d c=%0d want 1 %0d %0d",
                 k, dv[1], od[1], oc[1], exd[k], exc[k]);
      end
    end
    for (int k = 0; k < 10; k++) begin
      din_data = 8'd1; din_eot = (k == 9) ? 2'b01 : 2'b00;
      tick();
    end
    total++;
    if (oc[1] !== 16'd7 || od[1] !== 32'd10) begin
      bad++; $display("FAIL cnt_sat: got c=%0d d=%0d want 7 10", oc[1], od[1]);
    end
    total++;
    if (oc[0] !== 16'd10 || od[0] !== 32'd10) begin
      bad++; $display("FAIL cnt_wide: got c=%0d d=%0d want 10 10", oc[0], od[0]);
    end
    din_valid = 1'b0;
  endtask

  task automatic test_saturate();
    logic [7:0] dat [3] = '{8'd100, 8'd100, 8'hCE};
    logic [1:0] eot [3] = '{2'b00, 2'b00, 2'b01};
    apply_reset();
    for (int k = 0; k < 3; k++) begin
      din_valid = 1'b1; din_data = dat[k]; din_eot = eot[k];
      tick();
      if (k == 1) begin
        total++;
        if (od[2] !== 32'h7F || ov[2] !== 1'b1) begin
          bad++; $display("FAIL sat_pos: got d=%0h o=%b want 7f 1", od[2], ov[2]);
        end
      end
    end
    total++;
    if (od[2] !== 32'd77 || ov[2] !== 1'b1 || oc[2] !== 16'd3) begin
      bad++;
      $display("FAIL sat_after: got d=%0d o=%b c=%0d want 77 1 3", od[2], ov[2], oc[2]);
    end
    din_data = 8'h80; din_eot = 2'b00; tick();
    din_data = 8'h80; din_eot = 2'b01; tick();
    total++;
    if (od[2] !== 32'h80 || ov[2] !== 1'b1) begin
      bad++; $display("FAIL sat_neg: got d=%0h o=%b want 80 1", od[2], ov[2]);
    end
    for (int k = 0; k < 3; k++) begin
      din_data = 8'hFF; din_eot = (k == 2) ? 2'b01 : 2'b00;
      tick();
    end
    total++;
    if (od[4] !== 32'h1FF || ov[4] !== 1'b1) begin
      bad++; $display("FAIL usat: got d=%0h o=%b want 1ff 1", od[4], ov[4]);
    end
    total++;
    if (od[2] !== 32'hFD || ov[2] !== 1'b0) begin
      bad++; $display("FAIL sneg_ok: got d=%0h o=%b want fd 0", od[2], ov[2]);
    end
    din_valid = 1'b0;
  endtask

  task automatic test_wrap();
    apply_reset();
    din_valid = 1'b1;
    din_data = 8'd200; din_eot = 2'b00; tick();
    din_data = 8'd100; din_eot = 2'b10; tick();
    total++;
    if (dv[3] !== 1'b1 || od[3] !== 32'd44 || ov[3] !== 1'b1 ||
        oc[3] !== 16'd2 || oe[3] !== 2'b10) begin
      bad++;
      $display("FAIL wrap_res: got v=%b d=%0d o=%b c=%0d e=%b want 1 44 1 2 10",
               dv[3], od[3], ov[3], oc[3], oe[3]);
    end
    din_data = 8'd5; din_eot = 2'b10; tick();
    total++;
    if (od[3] !== 32'd5 || ov[3] !== 1'b0 || oc[3] !== 16'd1) begin
      bad++;
      $display("FAIL wrap_next: got d=%0d o=%b c=%0d want 5 0 1", od[3], ov[3], oc[3]);
    end
    din_valid = 1'b0;
  endtask

  task automatic test_stall();
    apply_reset();
    din_valid = 1'b1; din_data = 8'd9; din_eot = 2'b01;
    tick();
    dout_ready = 1'b0; din_data = 8'd2;
    for (int k = 0; k < 5; k++) begin
      #1;
      total++;
      if (rdy[0] !== 1'b0 || dv[0] !== 1'b1 || od[0] !== 32'd9 ||
          oc[0] !== 16'd1 || oe[0] !== 2'b01) begin
        bad++;
        $display("FAIL stall%0d: got r=%b v=%b d=%0d c=%0d want 0 1 9 1",
                 k, rdy[0], dv[0], od[0], oc[0]);
      end
      tick();
    end
    dout_ready = 1'b1;
    #1;
    total++;
    if (rdy[0] !== 1'b1) begin
      bad++; $display("FAIL stall_rdy: got %b want 1", rdy[0]);
    end
    tick();
    total++;
    if (dv[0] !== 1'b1 || od[0] !== 32'd2) begin
      bad++; $display("FAIL no_bubble: got v=%b d=%0d want 1 2", dv[0], od[0]);
    end
    din_valid = 1'b0;
    tick();
    total++;
    if (dv[0] !== 1'b0) begin
      bad++; $display("FAIL stall_end: got %b want 0", dv[0]);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    din_valid = 1'b1; din_eot = 2'b00;
    din_data = 8'd1; tick();
    din_data = 8'd2; tick();
    rst = 1'b0;
    tick();
    #1;
    total++;
    if (dv !== '0 || rdy !== '0 || od[1] !== 32'd0 || oc[1] !== 16'd0) begin
      bad++;
      $display("FAIL mid_rst: got v=%b r=%b d1=%0d c1=%0d want 0", dv, rdy, od[1], oc[1]);
    end
    rst = 1'b1;
    din_data = 8'd9; din_eot = 2'b01;
    tick();
    total++;
    if (dv[0] !== 1'b1 || od[0] !== 32'd9 || oc[0] !== 16'd1 ||
        od[1] !== 32'd9 || oc[1] !== 16'd1) begin
      bad++;
      $display("FAIL mid_new: got v=%b d=%0d c=%0d d1=%0d c1=%0d want 1 9 1 9 1",
               dv[0], od[0], oc[0], od[1], oc[1]);
    end
    din_valid = 1'b0;
  endtask

  task automatic test_random();
    logic [31:0] exp_d;
    apply_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      rst        = ($urandom_range(0, 79) != 0);
      din_valid  = ($urandom_range(0, 3) != 0);
      din_data   = 8'($urandom);
      din_eot    = {($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0)};
      dout_ready = ($urandom_range(0, 3) != 0);
      #1;
      for (int i = 0; i < N; i++) begin
        total++;
        if (rdy[i] !== (rst && (!mv[i] || dout_ready)) || dv[i] !== mv[i]) begin
          bad++;
          $display("FAIL rnd_hs[%0d] cyc %0d: got r=%b v=%b want v=%b",
                   i, cyc, rdy[i], dv[i], mv[i]);
        end
        if (mv[i]) begin
          exp_d = 32'(md[i] & ((longint'(1) << wout[i]) - 1));
          total++;
          if (od[i] !== exp_d || oe[i] !== meot[i] ||
              oc[i] !== 16'(mcnt[i]) || ov[i] !== movf[i]) begin
            bad++;
            $display("FAIL rnd_out[%0d] cyc %0d: got d=%0h e=%b c=%0d o=%b want %0h %b %0d %b",
                     i, cyc, od[i], oe[i], oc[i], ov[i], exp_d, meot[i], mcnt[i], movf[i]);
          end
        end
      end
      tick();
    end
    din_valid = 1'b0;
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; din_valid = 1'b0; dout_ready = 1'b1;
    din_data = '0; din_eot = '0;
    @(negedge clk);
    test_reset();
    test_group();
    test_partial();
    test_saturate();
    test_wrap();
    test_stall();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
